// File: rtl/smc_seq_pkg23.sv
// ---------------------------------------------------------------------------
// smc_seq_pkg23
// Shared definitions for the static memory controller address sequencer:
//   - transfer / bus size encodings (log2 of the byte count)
//   - sequencer state enum
//   - sub_count(): index of the last sub-access within one beat
// ---------------------------------------------------------------------------
package smc_seq_pkg23;

    // Transfer size (AHB side), log2 bytes
    typedef enum logic [1:0] {
        XSIZ_8  = 2'd0,
        XSIZ_16 = 2'd1,
        XSIZ_32 = 2'd2,
        XSIZ_64 = 2'd3
    } xsize_e;

    // External bus size of the selected bank, log2 bytes
    typedef enum logic [1:0] {
        BSIZ_8  = 2'd0,
        BSIZ_16 = 2'd1,
        BSIZ_32 = 2'd2,
        BSIZ_64 = 2'd3
    } bsize_e;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    // Number of bus-width sub-accesses per beat is 2**(xsize-bsize) when the
    // transfer is wider than the bus, otherwise 1. The sub counter runs from
    // that count minus one down to zero, so the function returns S-1.
    function automatic logic [2:0] sub_count(input logic [1:0] xsize,
                                             input logic [1:0] bsize);
        logic [3:0] s;
        s = (xsize > bsize) ? (4'd1 << (xsize - bsize)) : 4'd1;
        return 3'(s - 4'd1);
    endfunction

endpackage

// File: rtl/smc_lane_dec23.sv
// ---------------------------------------------------------------------------
// smc_lane_dec23
// Combinational byte-lane decoder: produces the active-low byte enables for
// one external sub-access.
//   bsize    in  2           log2 external bus bytes
//   xsize    in  2           log2 transfer bytes
//   addr_lo  in  3           low address bits of the sub-access
//   big_end  in  1           big-endian lane mapping
//   n_be     out DATA_BYTES  active-low byte lanes
// Lanes at or above the bus width W=2**bsize are never enabled.
// ---------------------------------------------------------------------------
module smc_lane_dec23 #(
    parameter int DATA_BYTES = 4
) (
    input  logic [1:0]            bsize,
    input  logic [1:0]            xsize,
    input  logic [2:0]            addr_lo,
    input  logic                  big_end,
    output logic [DATA_BYTES-1:0] n_be
);

    always_comb begin
        int w;
        int n;
        int pos;
        int lo;
        int hi;

        w   = 1 << bsize;
        n   = 1 << xsize;
        pos = int'(addr_lo) & (w - 1);

        if (xsize >= bsize) begin
            // Transfer fills the whole bus word
            lo = 0;
            hi = w - 1;
        end else if (big_end) begin
            // Big-endian: byte 0 of the bus word sits on the top lane, and
            // wider narrow transfers extend downward from there
            hi = w - 1 - pos;
            lo = hi - n + 1;
        end else begin
            lo = pos;
            hi = pos + n - 1;
        end

        n_be = '1;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if ((i >= lo) && (i <= hi) && (i < w)) begin
                n_be[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/smc_addr_seq23.sv
// ---------------------------------------------------------------------------
// smc_addr_seq23
// Address / chip-select / byte-enable sequencer for the static memory
// controller. Takes one request from the AHB-side front end and walks the
// external sub-accesses (bus-width pieces of each beat, across all beats),
// advancing on mem_done23 from the SMC timing state machine.
//
// Ports
//   sys_clk23      in   system clock
//   sys_reset23    in   asynchronous active-high reset
//   req_valid23    in   request strobe
//   req_ready23    out  high while idle; handshake = valid & ready
//   req_addr23     in   byte address of first beat
//   req_cs23       in   one-hot bank select
//   req_xsize23    in   log2 transfer bytes
//   req_bsize23    in   log2 external bus bytes of the bank
//   req_big_end23  in   big-endian lane/order mapping
//   req_beats23    in   beats minus one
//   mem_done23     in   current external sub-access complete
//   smc_addr23     out  external address (registered)
//   smc_n_cs23     out  active-low chip selects (registered)
//   smc_n_be23     out  active-low byte lanes (registered)
//   smc_last23     out  current sub-access is the final one of the request
//   req_err23      out  one-cycle pulse: request rejected
// ---------------------------------------------------------------------------
module smc_addr_seq23
    import smc_seq_pkg23::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_BYTES = 4,
    parameter int NUM_CS     = 8,
    parameter int BURST_W    = 4
) (
    input  logic                  sys_clk23,
    input  logic                  sys_reset23,
    input  logic                  req_valid23,
    output logic                  req_ready23,
    input  logic [ADDR_W-1:0]     req_addr23,
    input  logic [NUM_CS-1:0]     req_cs23,
    input  logic [1:0]            req_xsize23,
    input  logic [1:0]            req_bsize23,
    input  logic                  req_big_end23,
    input  logic [BURST_W-1:0]    req_beats23,
    input  logic                  mem_done23,
    output logic [ADDR_W-1:0]     smc_addr23,
    output logic [NUM_CS-1:0]     smc_n_cs23,
    output logic [DATA_BYTES-1:0] smc_n_be23,
    output logic                  smc_last23,
    output logic                  req_err23
);

    localparam int LOG2_DB = $clog2(DATA_BYTES);

    // Sequencer state and captured request
    state_e              state;
    logic [ADDR_W-1:0]   base;
    logic [2:0]          sub_cnt;
    logic [BURST_W-1:0]  beat_cnt;
    logic [NUM_CS-1:0]   cap_cs;
    logic [1:0]          cap_xsize;
    logic [1:0]          cap_bsize;
    logic                cap_big;
    logic [BURST_W-1:0]  cap_beats;

    // Next-cycle values
    state_e              nxt_state;
    logic [ADDR_W-1:0]   nxt_base;
    logic [2:0]          nxt_sub;
    logic [BURST_W-1:0]  nxt_beat;
    logic [NUM_CS-1:0]   nxt_cs;
    logic [1:0]          nxt_xsize;
    logic [1:0]          nxt_bsize;
    logic                nxt_big;
    logic [BURST_W-1:0]  nxt_beats;
    logic                issue;
    logic                finish;
    logic                reject;
    logic                legal;
    logic [2:0]          offset;
    logic [ADDR_W-1:0]   nxt_addr;
    logic                nxt_last;
    logic [DATA_BYTES-1:0] lane_n_be;

    assign legal = (int'(req_xsize23) <= LOG2_DB) &&
                   (int'(req_bsize23) <= LOG2_DB) &&
                   $onehot(req_cs23);

    always_comb begin
        nxt_state = state;
        nxt_base  = base;
        nxt_sub   = sub_cnt;
        nxt_beat  = beat_cnt;
        nxt_cs    = cap_cs;
        nxt_xsize = cap_xsize;
        nxt_bsize = cap_bsize;
        nxt_big   = cap_big;
        nxt_beats = cap_beats;
        issue     = 1'b0;
        finish    = 1'b0;
        reject    = 1'b0;

        if (state == IDLE) begin
            if (req_valid23) begin
                if (legal) begin
                    nxt_state = ACTIVE;
                    nxt_cs    = req_cs23;
                    nxt_xsize = req_xsize23;
                    nxt_bsize = req_bsize23;
                    nxt_big   = req_big_end23;
                    nxt_beats = req_beats23;
                    nxt_sub   = sub_count(req_xsize23, req_bsize23);
                    nxt_beat  = '0;
                    // Wide transfers are split into whole bus words, so the
                    // beat base is aligned to the transfer size
                    if (req_xsize23 > req_bsize23) begin
                        nxt_base = req_addr23 &
                                   ~((ADDR_W'(1) << req_xsize23) - ADDR_W'(1));
                    end else begin
                        nxt_base = req_addr23;
                    end
                    issue = 1'b1;
                end else begin
                    reject = 1'b1;
                end
            end
        end else if (mem_done23) begin
            if (smc_last23) begin
                nxt_state = IDLE;
                finish    = 1'b1;
            end else if (sub_cnt != 3'd0) begin
                nxt_sub = sub_cnt - 3'd1;
                issue   = 1'b1;
            end else begin
                // Beat complete: step to the next beat base (wraps freely)
                nxt_sub  = sub_count(cap_xsize, cap_bsize);
                nxt_beat = beat_cnt + BURST_W'(1);
                nxt_base = base + (ADDR_W'(1) << cap_xsize);
                issue    = 1'b1;
            end
        end
    end

    // Little-endian walks bus words from the highest offset down, which is
    // exactly the descending sub counter; big-endian walks upward from 0.
    assign offset   = nxt_big ? (sub_count(nxt_xsize, nxt_bsize) - nxt_sub) : nxt_sub;
    assign nxt_addr = nxt_base + (ADDR_W'(offset) << nxt_bsize);
    assign nxt_last = (nxt_sub == 3'd0) && (nxt_beat == nxt_beats);

    smc_lane_dec23 #(
        .DATA_BYTES(DATA_BYTES)
    ) u_lane_dec (
        .bsize   (nxt_bsize),
        .xsize   (nxt_xsize),
        .addr_lo (nxt_addr[2:0]),
        .big_end (nxt_big),
        .n_be    (lane_n_be)
    );

    always_ff @(posedge sys_clk23 or posedge sys_reset23) begin
        if (sys_reset23) begin
            state       <= IDLE;
            base        <= '0;
            sub_cnt     <= '0;
            beat_cnt    <= '0;
            cap_cs      <= '0;
            cap_xsize   <= '0;
            cap_bsize   <= '0;
            cap_big     <= 1'b0;
            cap_beats   <= '0;
            req_ready23 <= 1'b1;
            req_err23   <= 1'b0;
            smc_addr23  <= '0;
            smc_n_cs23  <= '1;
            smc_n_be23  <= '1;
            smc_last23  <= 1'b0;
        end else begin
            state       <= nxt_state;
            base        <= nxt_base;
            sub_cnt     <= nxt_sub;
            beat_cnt    <= nxt_beat;
            cap_cs      <= nxt_cs;
            cap_xsize   <= nxt_xsize;
            cap_bsize   <= nxt_bsize;
            cap_big     <= nxt_big;
            cap_beats   <= nxt_beats;
            req_ready23 <= (nxt_state == IDLE);
            req_err23   <= reject;
            if (issue) begin
                smc_addr23 <= nxt_addr;
                smc_n_cs23 <= ~nxt_cs;
                smc_n_be23 <= lane_n_be;
                smc_last23 <= nxt_last;
            end else if (finish) begin
                // Address is left as-is; selects and lanes are released
                smc_n_cs23 <= '1;
                smc_n_be23 <= '1;
                smc_last23 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_smc_addr_seq23.sv
module tb_smc_addr_seq23;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [7:0]  req_cs = '0;
    logic [1:0]  req_xsize = '0;
    logic [1:0]  req_bsize = '0;
    logic        req_big = 1'b0;
    logic [3:0]  req_beats = '0;
    logic        mem_done = 1'b0;
    logic [31:0] smc_addr;
    logic [7:0]  smc_n_cs;
    logic [3:0]  smc_n_be;
    logic        smc_last;
    logic        req_err;

    int errors = 0;
    int checks = 0;
    bit mon_on = 1'b0;

    always #5 clk = ~clk;

    smc_addr_seq23 #(
        .ADDR_W(32), .DATA_BYTES(4), .NUM_CS(8), .BURST_W(4)
    ) dut (
        .sys_clk23     (clk),
        .sys_reset23   (rst),
        .req_valid23   (req_valid),
        .req_ready23   (req_ready),
        .req_addr23    (req_addr),
        .req_cs23      (req_cs),
        .req_xsize23   (req_xsize),
        .req_bsize23   (req_bsize),
        .req_big_end23 (req_big),
        .req_beats23   (req_beats),
        .mem_done23    (mem_done),
        .smc_addr23    (smc_addr),
        .smc_n_cs23    (smc_n_cs),
        .smc_n_be23    (smc_n_be),
        .smc_last23    (smc_last),
        .req_err23     (req_err)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] a;
        logic [3:0]  be;
        bit          last;
    } sub_t;

    sub_t        q[$];
    bit          m_active;
    logic [7:0]  m_cs;
    logic [31:0] e_addr;
    logic [7:0]  e_ncs;
    logic [3:0]  e_nbe;
    bit          e_last, e_err, e_ready;

    function automatic logic [3:0] lanes(input logic [31:0] a, input int xs, input int bs, input bit big);
        logic [3:0] r;
        int w, n, p, lo, hi;
        r = 4'hF;
        w = 1 << bs;
        n = 1 << xs;
        p = int'(a & 32'(w - 1));
        if (xs >= bs) begin lo = 0; hi = w - 1; end
        else if (big) begin hi = w - 1 - p; lo = hi - n + 1; end
        else begin lo = p; hi = p + n - 1; end
        for (int i = 0; i < 4; i++)
            if (i >= lo && i <= hi && i < w) r[i] = 1'b0;
        return r;
    endfunction

    // Build the full list of sub-accesses for one request
    function automatic void expand(input logic [31:0] addr, input int xs, input int bs,
                                   input bit big, input int beats);
        int s, w, n, off;
        logic [31:0] start, bbase, a;
        sub_t e;
        s = (xs > bs) ? (1 << (xs - bs)) : 1;
        w = 1 << bs;
        n = 1 << xs;
        start = (xs > bs) ? (addr & ~(32'(n) - 32'd1)) : addr;
        q.delete();
        for (int k = 0; k <= beats; k++) begin
            bbase = start + 32'(k * n);
            for (int j = 0; j < s; j++) begin
                off    = big ? j : (s - 1 - j);
                a      = bbase + 32'(off * w);
                e.a    = a;
                e.be   = lanes(a, xs, bs, big);
                e.last = (k == beats) && (j == s - 1);
                q.push_back(e);
            end
        end
    endfunction

    task automatic model_pop();
        sub_t e;
        e = q.pop_front();
        e_addr = e.a;
        e_nbe  = e.be;
        e_last = e.last;
        e_ncs  = ~m_cs;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_active = 1'b0;
            m_cs = '0;
            e_addr = '0; e_ncs = '1; e_nbe = '1;
            e_last = 1'b0; e_err = 1'b0; e_ready = 1'b1;
        end else begin
            e_err = 1'b0;
            if (!m_active) begin
                if (req_valid) begin
                    if (req_xsize <= 2 && req_bsize <= 2 && $countones(req_cs) == 1) begin
                        m_cs = req_cs;
                        expand(req_addr, int'(req_xsize), int'(req_bsize), req_big, int'(req_beats));
                        model_pop();
                        m_active = 1'b1;
                        e_ready  = 1'b0;
                    end else begin
                        e_err = 1'b1;
                    end
                end
            end else if (mem_done) begin
                if (q.size() == 0) begin
                    e_ncs = '1; e_nbe = '1; e_last = 1'b0;
                    m_active = 1'b0;
                    e_ready  = 1'b1;
                end else begin
                    model_pop();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            chk("mdl_addr",  smc_addr,  e_addr);
            chk("mdl_n_cs",  {24'd0, smc_n_cs}, {24'd0, e_ncs});
            chk("mdl_n_be",  {28'd0, smc_n_be}, {28'd0, e_nbe});
            chk("mdl_last",  {31'd0, smc_last}, {31'd0, e_last});
            chk("mdl_err",   {31'd0, req_err},  {31'd0, e_err});
            chk("mdl_ready", {31'd0, req_ready}, {31'd0, e_ready});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic send(input logic [31:0] a, input logic [7:0] cs, input logic [1:0] xs,
                        input logic [1:0] bs, input bit big, input logic [3:0] beats);
        req_addr = a; req_cs = cs; req_xsize = xs; req_bsize = bs;
        req_big = big; req_beats = beats; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        // scramble fields: captured values must be used from here on
        req_addr = 32'hDEAD_BEEF; req_cs = 8'hFF; req_xsize = 2'd3;
        req_bsize = 2'd3; req_big = ~big; req_beats = 4'hF;
    endtask

    task automatic step();
        mem_done = 1'b1;
        @(posedge clk); #1;
        mem_done = 1'b0;
    endtask

    task automatic sub(input string nm, input logic [31:0] a, input logic [3:0] be,
                       input bit last, input logic [7:0] ncs);
        chk({nm, "_addr"}, smc_addr, a);
        chk({nm, "_nbe"},  {28'd0, smc_n_be}, {28'd0, be});
        chk({nm, "_last"}, {31'd0, smc_last}, {31'd0, last});
        chk({nm, "_ncs"},  {24'd0, smc_n_cs}, {24'd0, ncs});
    endtask

    task automatic idle_chk(input string nm);
        chk({nm, "_ncs"},   {24'd0, smc_n_cs}, 32'h0000_00FF);
        chk({nm, "_nbe"},   {28'd0, smc_n_be}, 32'h0000_000F);
        chk({nm, "_last"},  {31'd0, smc_last}, 32'd0);
        chk({nm, "_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        mon_on = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_addr", smc_addr, 32'd0);
        chk("rst_err", {31'd0, req_err}, 32'd0);
        idle_chk("rst");

        // mem_done while idle is ignored
        step();
        idle_chk("idle_done");

        // 1: 32b on 8b bus, LE
        send(32'h100, 8'h04, 2'd2, 2'd0, 1'b0, 4'd0);
        chk("t1_ready", {31'd0, req_ready}, 32'd0);
        sub("t1s0", 32'h103, 4'hE, 1'b0, 8'hFB);
        req_valid = 1'b1; req_cs = 8'h01; req_xsize = 2'd0;   // ignored while busy
        step();
        req_valid = 1'b0;
        sub("t1s1", 32'h102, 4'hE, 1'b0, 8'hFB);
        @(posedge clk); #1;                                   // no done: hold
        sub("t1hold", 32'h102, 4'hE, 1'b0, 8'hFB);
        step(); sub("t1s2", 32'h101, 4'hE, 1'b0, 8'hFB);
        step(); sub("t1s3", 32'h100, 4'hE, 1'b1, 8'hFB);
        step(); idle_chk("t1end");

        // 2: same, big-endian
        send(32'h100, 8'h04, 2'd2, 2'd0, 1'b1, 4'd0);
        sub("t2s0", 32'h100, 4'hE, 1'b0, 8'hFB);
        step(); sub("t2s1", 32'h101, 4'hE, 1'b0, 8'hFB);
        step(); sub("t2s2", 32'h102, 4'hE, 1'b0, 8'hFB);
        step(); sub("t2s3", 32'h103, 4'hE, 1'b1, 8'hFB);
        step(); idle_chk("t2end");

        // 3: 8b on 32b bus
        send(32'h2, 8'h10, 2'd0, 2'd2, 1'b0, 4'd0);
        sub("t3le", 32'h2, 4'b1011, 1'b1, 8'hEF);
        step(); idle_chk("t3le_end");
        send(32'h2, 8'h10, 2'd0, 2'd2, 1'b1, 4'd0);
        sub("t3be", 32'h2, 4'b1101, 1'b1, 8'hEF);
        step(); idle_chk("t3be_end");

        // 16b on 32b bus, LE, offset 2
        send(32'h2, 8'h02, 2'd1, 2'd2, 1'b0, 4'd0);
        sub("t3h", 32'h2, 4'b0011, 1'b1, 8'hFD);
        step(); idle_chk("t3h_end");

        // 4: 16b on 16b bus, 4 beats, wrapping
        send(32'hFFFF_FFFC, 8'h01, 2'd1, 2'd1, 1'b0, 4'd3);
        sub("t4b0", 32'hFFFF_FFFC, 4'b1100, 1'b0, 8'hFE);
        step(); sub("t4b1", 32'hFFFF_FFFE, 4'b1100, 1'b0, 8'hFE);
        step(); sub("t4b2", 32'h0000_0000, 4'b1100, 1'b0, 8'hFE);
        step(); sub("t4b3", 32'h0000_0002, 4'b1100, 1'b1, 8'hFE);
        step(); idle_chk("t4end");

        // 32b on 16b bus, BE, misaligned start, 2 beats
        send(32'h203, 8'h80, 2'd2, 2'd1, 1'b1, 4'd1);
        sub("tws0", 32'h200, 4'b1100, 1'b0, 8'h7F);
        step(); sub("tws1", 32'h202, 4'b1100, 1'b0, 8'h7F);
        step(); sub("tws2", 32'h204, 4'b1100, 1'b0, 8'h7F);
        step(); sub("tws3", 32'h206, 4'b1100, 1'b1, 8'h7F);
        step(); idle_chk("twend");

        // 5: illegal requests
        send(32'h40, 8'h02, 2'd3, 2'd2, 1'b0, 4'd0);
        chk("t5_err", {31'd0, req_err}, 32'd1);
        chk("t5_addr", smc_addr, 32'h206);
        idle_chk("t5");
        @(posedge clk); #1;
        chk("t5_err_clr", {31'd0, req_err}, 32'd0);
        send(32'h40, 8'h00, 2'd0, 2'd0, 1'b0, 4'd0);
        chk("t5_cs0_err", {31'd0, req_err}, 32'd1);
        send(32'h40, 8'h06, 2'd0, 2'd0, 1'b0, 4'd0);
        chk("t5_cs2_err", {31'd0, req_err}, 32'd1);
        send(32'h40, 8'h01, 2'd0, 2'd3, 1'b0, 4'd0);
        chk("t5_bs_err", {31'd0, req_err}, 32'd1);
        idle_chk("t5end");

        // 6: reset mid-sequence
        send(32'h100, 8'h04, 2'd2, 2'd0, 1'b0, 4'd0);
        step(); step();
        sub("t6pre", 32'h101, 4'hE, 1'b0, 8'hFB);
        #2 rst = 1'b1;
        #1;
        chk("t6_addr", smc_addr, 32'd0);
        idle_chk("t6rst");
        @(posedge clk); #1 rst = 1'b0;
        send(32'h2, 8'h10, 2'd0, 2'd2, 1'b1, 4'd0);
        sub("t6new", 32'h2, 4'b1101, 1'b1, 8'hEF);
        step(); idle_chk("t6end");

        @(posedge clk); #1;
        mon_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
